// File: rtl/parameter_shadow_ram_if.sv
// parameter_shadow_ram_if: Avalon-MM host (s1, shadow bank) and consumer (s2, active bank) slave signals
interface parameter_shadow_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0] s1_address;
  logic [DATA_WIDTH/BYTE_WIDTH-1:0] s1_byteenable;
  logic s1_chipselect;
  logic s1_write;
  logic s1_read;
  logic [DATA_WIDTH-1:0] s1_writedata;
  logic [DATA_WIDTH-1:0] s1_readdata;
  logic s1_readdatavalid;
  logic s1_waitrequest;
  logic [ADDR_WIDTH-1:0] s2_address;
  logic s2_chipselect;
  logic s2_read;
  logic [DATA_WIDTH-1:0] s2_readdata;
  logic s2_readdatavalid;
  modport master (
    output s1_address, s1_byteenable, s1_chipselect, s1_write, s1_read, s1_writedata,
    output s2_address, s2_chipselect, s2_read,
    input s1_readdata, s1_readdatavalid, s1_waitrequest, s2_readdata, s2_readdatavalid
  );
  modport slave (
    input s1_address, s1_byteenable, s1_chipselect, s1_write, s1_read, s1_writedata,
    input s2_address, s2_chipselect, s2_read,
    output s1_readdata, s1_readdatavalid, s1_waitrequest, s2_readdata, s2_readdatavalid
  );
endinterface

// File: rtl/parameter_shadow_ram.sv
// parameter_shadow_ram: double-buffered parameter RAM with atomic bank swap and optional copy-back
module parameter_shadow_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH = 1025,
  parameter int READ_LATENCY = 1,
  parameter int COPY_ON_COMMIT = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  parameter_shadow_ram_if.slave bus,
  input  logic freeze,
  input  logic commit_req,
  output logic commit_done,
  output logic busy,
  output logic active_bank,
  output logic [CNT_WIDTH-1:0] commit_count
);
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, SWAP, COPY} state_t;
  state_t state, state_n;
  logic pending, pending_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] mem [2][DEPTH];
  logic cp_we;
  logic [IW-1:0] cp_addr;
  logic [DATA_WIDTH-1:0] cp_data;
  logic stall, s1_acc, s2_acc, s1_ok, s2_ok;
  logic [IW-1:0] s1_idx, s2_idx;
  logic [1:0] v1, v2;
  logic [1:0][DATA_WIDTH-1:0] r1, r2;
  assign stall = state == COPY;
  assign s1_acc = bus.s1_chipselect & (bus.s1_read | bus.s1_write) & ~stall;
  assign s2_acc = bus.s2_chipselect & bus.s2_read;
  assign s1_ok = 32'(bus.s1_address) < DEPTH;
  assign s2_ok = 32'(bus.s2_address) < DEPTH;
  assign s1_idx = bus.s1_address[IW-1:0];
  assign s2_idx = bus.s2_address[IW-1:0];
  assign busy = state != IDLE || pending;
  assign commit_done = (state == SWAP && COPY_ON_COMMIT == 0) || (state == COPY && cnt == CW'(DEPTH));
  assign bus.s1_waitrequest = stall;
  assign bus.s1_readdatavalid = READ_LATENCY == 2 ? v2[0] : v1[0];
  assign bus.s1_readdata = READ_LATENCY == 2 ? r2[0] : r1[0];
  assign bus.s2_readdatavalid = READ_LATENCY == 2 ? v2[1] : v1[1];
  assign bus.s2_readdata = READ_LATENCY == 2 ? r2[1] : r1[1];
  always_comb begin
    state_n = state == IDLE ? (((commit_req | pending) & ~freeze) ? SWAP : IDLE)
            : state == SWAP ? (COPY_ON_COMMIT != 0 ? COPY : IDLE)
            : (cnt == CW'(DEPTH) ? IDLE : COPY);
    pending_n = (state == IDLE && !freeze) ? 1'b0 : state == SWAP ? commit_req : pending | commit_req;
    cnt_n = state == COPY ? cnt + CW'(1) : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pending <= 1'b0;
      cnt <= '0;
      active_bank <= 1'b0;
      commit_count <= '0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      cnt <= cnt_n;
      if (state == SWAP) active_bank <= ~active_bank;
      if (commit_done) commit_count <= commit_count + CNT_WIDTH'(1);
    end
  // bank is sampled at accept, so reads straddling a swap still return old-bank data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cp_we <= 1'b0;
      cp_addr <= '0;
      cp_data <= '0;
      v1 <= '0;
      v2 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else begin
      cp_we <= state == COPY && 32'(cnt) < DEPTH;
      cp_addr <= cnt[IW-1:0];
      if (32'(cnt) < DEPTH) cp_data <= mem[active_bank][cnt[IW-1:0]];
      v1 <= {s2_acc, s1_acc & bus.s1_read};
      v2 <= v1;
      r1[0] <= s1_ok ? mem[~active_bank][s1_idx] : '0;
      r1[1] <= s2_ok ? mem[active_bank][s2_idx] : '0;
      r2 <= r1;
    end
  always_ff @(posedge clk) begin
    if (cp_we) mem[~active_bank][cp_addr] <= cp_data;
    if (s1_acc && bus.s1_write && s1_ok)
      for (int i = 0; i < LANES; i++)
        if (bus.s1_byteenable[i]) mem[~active_bank][s1_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.s1_writedata[i*BYTE_WIDTH +: BYTE_WIDTH];
  end
endmodule

// File: tb/tb_parameter_shadow_ram.sv
// tb_parameter_shadow_ram: directed stimulus with a read scoreboard; dut_a copies on commit, dut_b does not
module tb_parameter_shadow_ram;
  typedef struct { logic [31:0] d; int due; } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic freeze_a = 1'b0, req_a = 1'b0, done_a, busy_a, ab_a;
  logic freeze_b = 1'b0, req_b = 1'b0, done_b, busy_b, ab_b;
  logic [15:0] cnt_a;
  logic [1:0] cnt_b;
  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t q [4][$];
  logic ab_m [2];
  logic [15:0] cnt_m [2];
  parameter_shadow_ram_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(11)) ia ();
  parameter_shadow_ram_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(11)) ib ();
  parameter_shadow_ram #(.DEPTH(8), .READ_LATENCY(1), .COPY_ON_COMMIT(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave), .freeze(freeze_a), .commit_req(req_a),
    .commit_done(done_a), .busy(busy_a), .active_bank(ab_a), .commit_count(cnt_a));
  parameter_shadow_ram #(.DEPTH(8), .READ_LATENCY(2), .COPY_ON_COMMIT(0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave), .freeze(freeze_b), .commit_req(req_b),
    .commit_done(done_b), .busy(busy_b), .active_bank(ab_b), .commit_count(cnt_b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] stat(input int d);
    return d == 0 ? {12'b0, ab_a, ia.s1_waitrequest, done_a, busy_a, cnt_a}
                  : {12'b0, ab_b, ib.s1_waitrequest, done_b, busy_b, 14'b0, cnt_b};
  endfunction
  function automatic logic [31:0] mk(input logic ab, w, dn, b, input logic [15:0] c);
    return {12'b0, ab, w, dn, b, c};
  endfunction
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %h, want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  task automatic pop(input int i, input logic [31:0] act);
    exp_t x;
    n_chk++;
    if (q[i].size() == 0) begin
      n_fail++;
      $display("FAIL rd%0d unexpected valid: got %h at cycle %0d, want no valid", i, act, cyc);
    end else begin
      x = q[i].pop_front();
      if (x.d !== act || x.due != cyc) begin
        n_fail++;
        $display("FAIL rd%0d: got %h at cycle %0d, want %h at cycle %0d", i, act, cyc, x.d, x.due);
      end
    end
  endtask
  always @(negedge clk) begin
    if (ia.s1_readdatavalid) pop(0, ia.s1_readdata);
    if (ia.s2_readdatavalid) pop(1, ia.s2_readdata);
    if (ib.s1_readdatavalid) pop(2, ib.s1_readdata);
    if (ib.s2_readdatavalid) pop(3, ib.s2_readdata);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_s1(input int d, input logic rd, input logic wr, input logic [10:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (d == 0) begin
      ia.s1_chipselect = rd | wr; ia.s1_read = rd; ia.s1_write = wr;
      ia.s1_address = a; ia.s1_writedata = wd; ia.s1_byteenable = be;
    end else begin
      ib.s1_chipselect = rd | wr; ib.s1_read = rd; ib.s1_write = wr;
      ib.s1_address = a; ib.s1_writedata = wd; ib.s1_byteenable = be;
    end
  endtask
  task automatic set_s2(input int d, input logic rd, input logic [10:0] a);
    if (d == 0) begin
      ia.s2_chipselect = rd; ia.s2_read = rd; ia.s2_address = a;
    end else begin
      ib.s2_chipselect = rd; ib.s2_read = rd; ib.s2_address = a;
    end
  endtask
  task automatic set_req(input int d, input logic v);
    if (d == 0) req_a = v;
    else req_b = v;
  endtask
  task automatic push(input int i, input logic [31:0] e, input int lat);
    exp_t x;
    x.d = e;
    x.due = cyc + lat;
    q[i].push_back(x);
  endtask
  task automatic wr(input int d, input logic [10:0] a, input logic [31:0] wd, input logic [3:0] be);
    set_s1(d, 1'b0, 1'b1, a, wd, be);
    tick;
    set_s1(d, 1'b0, 1'b0, 11'd0, 32'd0, 4'd0);
  endtask
  task automatic rd(input int d, input int p, input logic [10:0] a, input logic [31:0] e);
    if (p == 1) set_s1(d, 1'b1, 1'b0, a, 32'd0, 4'd0);
    else set_s2(d, 1'b1, a);
    push(2 * d + p - 1, e, d == 0 ? 1 : 2);
    tick;
    set_s1(d, 1'b0, 1'b0, 11'd0, 32'd0, 4'd0);
    set_s2(d, 1'b0, 11'd0);
  endtask
  task automatic rw(input int d, input logic [10:0] a, input logic [31:0] wd, input logic [31:0] e);
    set_s1(d, 1'b1, 1'b1, a, wd, 4'hF);
    push(2 * d, e, d == 0 ? 1 : 2);
    tick;
    set_s1(d, 1'b0, 1'b0, 11'd0, 32'd0, 4'd0);
  endtask
  task automatic commit(input int d, input logic wr1, input logic [10:0] wa, input logic [31:0] wd);
    logic a0;
    logic [15:0] c0, c1;
    a0 = ab_m[d];
    c0 = cnt_m[d];
    c1 = d == 0 ? c0 + 16'd1 : (c0 + 16'd1) & 16'd3;
    set_req(d, 1'b1);
    tick;
    set_req(d, 1'b0);
    if (wr1) set_s1(d, 1'b0, 1'b1, wa, wd, 4'hF);
    check("commit_swap", stat(d), mk(a0, 1'b0, d == 1, 1'b1, c0));
    tick;
    set_s1(d, 1'b0, 1'b0, 11'd0, 32'd0, 4'd0);
    if (d == 0)
      for (int k = 2; k <= 10; k++) begin
        check("commit_copy", stat(d), mk(~a0, 1'b1, k == 10, 1'b1, c0));
        tick;
      end
    check("commit_end", stat(d), mk(~a0, 1'b0, 1'b0, 1'b0, c1));
    ab_m[d] = ~a0;
    cnt_m[d] = c1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
    $fatal(1);
  end
  initial begin
    set_s1(0, 1'b0, 1'b0, 11'd0, 32'd0, 4'd0);
    set_s1(1, 1'b0, 1'b0, 11'd0, 32'd0, 4'd0);
    set_s2(0, 1'b0, 11'd0);
    set_s2(1, 1'b0, 11'd0);
    ab_m = '{1'b0, 1'b0};
    cnt_m = '{16'd0, 16'd0};
    repeat (3) tick;
    reset = 1'b0;
    tick;
    check("reset_a", stat(0), 32'd0);
    check("reset_b", stat(1), 32'd0);
    // seed active bank; the write in the swap cycle must be part of the commit
    wr(0, 11'd3, 32'h0BADF00D, 4'hF);
    commit(0, 1'b1, 11'd6, 32'h66666666);
    rd(0, 2, 11'd6, 32'h66666666);
    rd(0, 1, 11'd6, 32'h66666666);
    wr(0, 11'd3, 32'hA5A5A5A5, 4'hF);
    rd(0, 1, 11'd3, 32'hA5A5A5A5);
    rd(0, 2, 11'd3, 32'h0BADF00D);
    wr(0, 11'd3, 32'hFFFFFFFF, 4'hF);
    wr(0, 11'd3, 32'h11223344, 4'b0101);
    rd(0, 1, 11'd3, 32'hFF22FF44);
    wr(0, 11'd4, 32'hCAFEBABE, 4'hF);
    rw(0, 11'd4, 32'h12345678, 32'hCAFEBABE);
    rd(0, 1, 11'd4, 32'h12345678);
    wr(0, 11'd0, 32'h0000AAAA, 4'hF);
    wr(0, 11'd8, 32'hDEADDEAD, 4'hF);
    rd(0, 1, 11'd0, 32'h0000AAAA);
    rd(0, 1, 11'd8, 32'd0);
    rd(0, 2, 11'd8, 32'd0);
    rd(0, 1, 11'h7FF, 32'd0);
    commit(0, 1'b0, 11'd0, 32'd0);
    rd(0, 2, 11'd3, 32'hFF22FF44);
    rd(0, 1, 11'd3, 32'hFF22FF44);
    rd(0, 2, 11'd4, 32'h12345678);
    rd(0, 1, 11'd0, 32'h0000AAAA);
    freeze_a = 1'b1;
    set_req(0, 1'b1); tick; set_req(0, 1'b0); tick;
    set_req(0, 1'b1); tick; set_req(0, 1'b0); tick; tick;
    check("frozen", stat(0), mk(ab_m[0], 1'b0, 1'b0, 1'b1, cnt_m[0]));
    freeze_a = 1'b0;
    repeat (10) tick;
    check("thaw_done", stat(0), mk(~ab_m[0], 1'b1, 1'b1, 1'b1, cnt_m[0]));
    tick;
    ab_m[0] = ~ab_m[0];
    cnt_m[0] = cnt_m[0] + 16'd1;
    check("thaw_end", stat(0), mk(ab_m[0], 1'b0, 1'b0, 1'b0, cnt_m[0]));
    repeat (20) tick;
    check("collapsed", stat(0), mk(ab_m[0], 1'b0, 1'b0, 1'b0, cnt_m[0]));
    wr(1, 11'd3, 32'h11111111, 4'hF);
    commit(1, 1'b0, 11'd0, 32'd0);
    wr(1, 11'd3, 32'h22222222, 4'hF);
    set_req(1, 1'b1);
    tick;
    set_req(1, 1'b0);
    rd(1, 2, 11'd3, 32'h11111111);
    rd(1, 2, 11'd3, 32'h22222222);
    ab_m[1] = 1'b0;
    cnt_m[1] = 16'd2;
    check("inflight_state", stat(1), mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd2));
    rd(1, 1, 11'd3, 32'h11111111);
    commit(1, 1'b0, 11'd0, 32'd0);
    commit(1, 1'b0, 11'd0, 32'd0);
    repeat (4) tick;
    set_req(0, 1'b1);
    tick;
    set_req(0, 1'b0);
    repeat (4) tick;
    reset = 1'b1;
    #1;
    check("midcopy_reset_a", stat(0), 32'd0);
    check("midcopy_reset_b", stat(1), 32'd0);
    tick; tick;
    reset = 1'b0;
    tick;
    check("post_reset_a", stat(0), 32'd0);
    rd(0, 1, 11'd8, 32'd0);
    rd(0, 2, 11'd8, 32'd0);
    repeat (4) tick;
    for (int i = 0; i < 4; i++) check("drain", 32'(q[i].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
